// File: rtl/cu_multicycle_fsm_if.sv
`default_nettype none
// ============================================================================
// Module      : cu_multicycle_fsm_if
// Description : Bundle between the multicycle control unit and the datapath.
//               It carries the instruction fields, the condition flag, the
//               memory handshake, all datapath enables/selects, and the
//               debug state and fault outputs.
//   master : the control unit. It reads Op/Funct/CondEx/MemReady and drives
//            everything else.
//   slave  : the datapath/memory side, in the opposite direction.
// Revision    : 1.0 - initial release
// ============================================================================
interface cu_multicycle_fsm_if;
  logic [1:0] Op;
  logic [5:0] Funct;
  logic       CondEx;
  logic       MemReady;
  logic       MemReq;
  logic       AdrSrc;
  logic       IRWrite;
  logic       PCWrite;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ResultSrc;
  logic       RegW;
  logic       MemW;
  logic       Branch;
  logic       ALUOp;
  logic [1:0] ImmSrc;
  logic [1:0] RegSrc;
  logic [3:0] State;
  logic       Fault;

  modport master (
    input  Op, Funct, CondEx, MemReady,
    output MemReq, AdrSrc, IRWrite, PCWrite, ALUSrcA, ALUSrcB, ResultSrc,
           RegW, MemW, Branch, ALUOp, ImmSrc, RegSrc, State, Fault
  );

  modport slave (
    output Op, Funct, CondEx, MemReady,
    input  MemReq, AdrSrc, IRWrite, PCWrite, ALUSrcA, ALUSrcB, ResultSrc,
           RegW, MemW, Branch, ALUOp, ImmSrc, RegSrc, State, Fault
  );
endinterface
`default_nettype wire

// File: rtl/cu_multicycle_fsm.sv
`default_nettype none
// ============================================================================
// Module      : cu_multicycle_fsm
// Description : Multicycle control unit for the ARM-subset processor. It walks
//               each instruction through fetch, decode, execute, memory and
//               writeback. It drives the datapath enables one state at a time
//               and stalls on the memory ready handshake.
// Ports       : clk   - clock, rising edge
//               rst_n - asynchronous active-low reset
//               bus   - cu_multicycle_fsm_if.master. Carries instruction
//                       fields in, CondEx, the MemReady/MemReq handshake, the
//                       datapath selects/enables, State (debug) and Fault.
// Parameters  : WAIT_MAX - consecutive stall cycles tolerated (1..65535)
// Options     : CU_FSM_WATCHDOG_EN - when defined, builds the stall
//               watchdog. When it expires the FSM moves to the sticky FAULT
//               state. When undefined, stalls last indefinitely and Fault is 0.
// Revision    : 1.0 - initial release
// ============================================================================
module cu_multicycle_fsm #(
  parameter int WAIT_MAX = 255
) (
  input  wire logic            clk,
  input  wire logic            rst_n,
  cu_multicycle_fsm_if.master  bus
);

  localparam int WAIT_W = $clog2(WAIT_MAX + 1);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXECR  = 4'd6,
    S_EXECI  = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9,
    S_FAULT  = 4'd15
  } state_t;

  state_t state_q, state_d;
  logic   wd_trip;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

`ifdef CU_FSM_WATCHDOG_EN
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(WAIT_MAX - 1);
  localparam logic [WAIT_W-1:0] WAIT_TOP  = WAIT_W'(WAIT_MAX);

  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              stall;

  // A stall is a memory-requesting state whose request has not completed.
  assign stall = ((state_q == S_FETCH) || (state_q == S_MEMRD) ||
                  (state_q == S_MEMWR)) && !bus.MemReady;

  // The counter clears on any non-stall cycle and saturates instead of wrapping.
  always_comb begin
    wait_d = '0;
    if (stall) begin
      wait_d = (wait_q == WAIT_TOP) ? wait_q : wait_q + WAIT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) wait_q <= '0;
    else        wait_q <= wait_d;
  end

  assign wd_trip   = stall && (wait_q == WAIT_LAST);
  assign bus.Fault = (state_q == S_FAULT);
`else
  assign wd_trip   = 1'b0;
  assign bus.Fault = 1'b0;
`endif

  // Next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:  if (bus.MemReady) state_d = S_DECODE;
      S_DECODE: begin
        // A failed condition wins over decode so the instruction has no side effects.
        if (!bus.CondEx) begin
          state_d = S_FETCH;
        end else begin
          case (bus.Op)
            2'b00:   state_d = bus.Funct[5] ? S_EXECI : S_EXECR;
            2'b01:   state_d = S_MEMADR;
            2'b10:   state_d = S_BRANCH;
            default: state_d = S_FETCH;
          endcase
        end
      end
      S_MEMADR: state_d = bus.Funct[0] ? S_MEMRD : S_MEMWR;
      S_MEMRD:  if (bus.MemReady) state_d = S_MEMWB;
      S_MEMWR:  if (bus.MemReady) state_d = S_FETCH;
      S_EXECR,
      S_EXECI:  state_d = S_ALUWB;
      S_MEMWB,
      S_ALUWB,
      S_BRANCH: state_d = S_FETCH;
      S_FAULT:  state_d = S_FAULT;
      default:  state_d = S_FETCH;
    endcase
    if (wd_trip) state_d = S_FAULT;
  end

  // Outputs
  logic       mem_req, adr_src, ir_write, pc_write, reg_w, mem_w, branch, alu_op;
  logic [1:0] alu_src_a, alu_src_b, result_src;

  always_comb begin
    mem_req    = 1'b0;
    adr_src    = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    reg_w      = 1'b0;
    mem_w      = 1'b0;
    branch     = 1'b0;
    alu_op     = 1'b0;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    result_src = 2'b00;
    case (state_q)
      S_FETCH: begin
        mem_req    = 1'b1;
        alu_src_a  = 2'b01;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        // Fetch completes in the MemReady cycle. MemReady is masked by reset
        // so that the IR and PC cannot load while reset is held.
        ir_write   = bus.MemReady & rst_n;
        pc_write   = bus.MemReady & rst_n;
      end
      S_DECODE: begin
        alu_src_a  = 2'b01;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
      end
      S_MEMADR: alu_src_b = 2'b01;
      S_MEMRD: begin
        mem_req = 1'b1;
        adr_src = 1'b1;
      end
      S_MEMWB: begin
        result_src = 2'b01;
        reg_w      = 1'b1;
      end
      S_MEMWR: begin
        mem_req = 1'b1;
        adr_src = 1'b1;
        mem_w   = 1'b1;
      end
      S_EXECR: alu_op = 1'b1;
      S_EXECI: begin
        alu_src_b = 2'b01;
        alu_op    = 1'b1;
      end
      S_ALUWB: reg_w = 1'b1;
      S_BRANCH: begin
        alu_src_b  = 2'b01;
        result_src = 2'b10;
        branch     = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.MemReq    = mem_req;
  assign bus.AdrSrc    = adr_src;
  assign bus.IRWrite   = ir_write;
  assign bus.PCWrite   = pc_write;
  assign bus.ALUSrcA   = alu_src_a;
  assign bus.ALUSrcB   = alu_src_b;
  assign bus.ResultSrc = result_src;
  assign bus.RegW      = reg_w;
  assign bus.MemW      = mem_w;
  assign bus.Branch    = branch;
  assign bus.ALUOp     = alu_op;
  assign bus.ImmSrc    = bus.Op;
  assign bus.RegSrc    = {(bus.Op == 2'b01) & ~bus.Funct[0], bus.Op == 2'b10};
  assign bus.State     = state_q;

endmodule
`default_nettype wire
